// File: rtl/bcd_down_timer.sv
// Packed-BCD countdown timer: a prescaler divides clk down to a decrement tick.
// Supports runtime load, start/pause/stop, one-shot or auto-reload, and a terminal-count pulse.
module bcd_down_timer #(
    parameter int                   DIGITS    = 6,
    parameter int                   DIV_COEFF = 50_000_000,
    parameter logic [4*DIGITS-1:0]  TIME_MAX  = 'h60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    input  logic                  mode_reload,
    output logic [4*DIGITS-1:0]   num,
    output logic                  running,
    output logic                  paused,
    output logic                  tc
);

    localparam int              W        = 4 * DIGITS;
    localparam int              PW       = (DIV_COEFF > 1) ? $clog2(DIV_COEFF) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV_COEFF - 1);
    localparam logic [W-1:0]    ONE      = W'(1);
    localparam logic [W-1:0]    ZERO     = '0;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [W-1:0]    reload;
    logic            tick;
    logic            last_shot;

    // Any nibble above 9 saturates to 9 so num can never hold a non-BCD digit.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Trailing zeros become 9 and the first non-zero digit takes the borrow.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick      = (presc == PRE_LAST);
    assign last_shot = tick && (num == ONE) && !mode_reload;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            presc   <= '0;
            reload  <= TIME_MAX;
            num     <= TIME_MAX;
            running <= 1'b0;
            paused  <= 1'b0;
            tc      <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                reload  <= bcd_clamp(load_val);
                num     <= bcd_clamp(load_val);
                presc   <= '0;
                state   <= IDLE;
                running <= 1'b0;
                paused  <= 1'b0;
            end else if (stop) begin
                num     <= reload;
                presc   <= '0;
                state   <= IDLE;
                running <= 1'b0;
                paused  <= 1'b0;
            end else if (start && (state == IDLE || state == DONE)) begin
                if (reload != ZERO) begin
                    num     <= reload;
                    presc   <= '0;
                    state   <= RUN;
                    running <= 1'b1;
                    paused  <= 1'b0;
                end
            end else if (start && state == PAUSE) begin
                state   <= RUN;
                running <= 1'b1;
                paused  <= 1'b0;
            end else if (state == RUN) begin
                presc <= tick ? '0 : presc + PW'(1);
                if (tick) begin
                    if (num == ONE) begin
                        tc <= 1'b1;
                        if (mode_reload) begin
                            num <= reload;
                        end else begin
                            num     <= ZERO;
                            state   <= DONE;
                            running <= 1'b0;
                            paused  <= 1'b0;
                        end
                    end else begin
                        num <= bcd_dec(num);
                    end
                end
                // A pause coinciding with the final one-shot tick still lands in DONE.
                if (pause && !last_shot) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                    paused  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: a 2-digit and a 6-digit instance, DIV_COEFF=4.
module tb_bcd_down_timer;

    logic        clk = 1'b0;
    logic        rst, load, start, pause, stop, mode_reload;
    logic [7:0]  load_val;
    logic [7:0]  num;
    logic        running, paused, tc;

    logic        load6, start6;
    logic [23:0] load_val6;
    logic [23:0] num6;
    logic        running6, paused6, tc6;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    bcd_down_timer #(.DIGITS(2), .DIV_COEFF(4), .TIME_MAX(8'h60)) dut2 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .pause(pause), .stop(stop), .mode_reload(mode_reload),
        .num(num), .running(running), .paused(paused), .tc(tc)
    );

    bcd_down_timer #(.DIGITS(6), .DIV_COEFF(4), .TIME_MAX(24'h60)) dut6 (
        .clk(clk), .rst(rst), .load(load6), .load_val(load_val6), .start(start6),
        .pause(1'b0), .stop(1'b0), .mode_reload(1'b0),
        .num(num6), .running(running6), .paused(paused6), .tc(tc6)
    );

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        mode_reload = 1'b0; load_val = 8'h00;
        load6 = 1'b0; start6 = 1'b0; load_val6 = 24'h0;
        cyc(2);
        chk("rst_num", num, 8'h60);
        chk("rst_running", running, 1'b0);
        chk("rst_paused", paused, 1'b0);
        chk("rst_tc", tc, 1'b0);

        // Count down from the reset value
        rst = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("start_running", running, 1'b1);
        chk("start_num", num, 8'h60);
        cyc(3);
        chk("pre_tick_num", num, 8'h60);
        cyc(1);
        chk("tick1_num", num, 8'h59);
        cyc(4);
        chk("tick2_num", num, 8'h58);
        cyc(32);
        chk("num_50", num, 8'h50);
        cyc(4);
        chk("borrow_49", num, 8'h49);

        // One-shot from 03
        load = 1'b1; load_val = 8'h03;
        cyc(1);
        load = 1'b0;
        chk("load03_num", num, 8'h03);
        chk("load03_idle", running, 1'b0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        chk("os_02", num, 8'h02);
        cyc(4);
        chk("os_01", num, 8'h01);
        cyc(3);
        chk("os_pre_tc", tc, 1'b0);
        cyc(1);
        chk("os_00", num, 8'h00);
        chk("os_tc", tc, 1'b1);
        chk("os_done_running", running, 1'b0);
        cyc(1);
        chk("os_tc_low", tc, 1'b0);
        cyc(20);
        chk("done_hold_num", num, 8'h00);
        chk("done_hold_tc", tc, 1'b0);

        // Auto-reload from 02
        load = 1'b1; load_val = 8'h02; mode_reload = 1'b1;
        cyc(1);
        load = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        chk("ar_01", num, 8'h01);
        cyc(4);
        chk("ar_reload_num", num, 8'h02);
        chk("ar_tc", tc, 1'b1);
        chk("ar_running", running, 1'b1);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!tc && n < 20);
        chk("ar_tc_period", n, 8);
        chk("ar_num_at_tc", num, 8'h02);

        // Pause 2 cycles after a tick, hold 10 cycles, resume
        cyc(2);
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
        chk("pause_paused", paused, 1'b1);
        chk("pause_running", running, 1'b0);
        cyc(10);
        chk("pause_hold_paused", paused, 1'b1);
        chk("pause_hold_num", num, 8'h02);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("resume_running", running, 1'b1);
        chk("resume_num", num, 8'h02);
        cyc(1);
        chk("resume_tick", num, 8'h01);

        // Stop on the terminal tick: no tc, num back to reload
        mode_reload = 1'b0;
        cyc(3);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_num", num, 8'h02);
        chk("stop_tc", tc, 1'b0);
        chk("stop_running", running, 1'b0);

        // Zero reload: start ignored
        load = 1'b1; load_val = 8'h00;
        cyc(1);
        load = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("zero_start_running", running, 1'b0);
        cyc(5);
        chk("zero_start_num", num, 8'h00);

        // Reset mid-run
        load = 1'b1; load_val = 8'h20;
        cyc(1);
        load = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        chk("midrun_num", num, 8'h19);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrun_rst_num", num, 8'h60);
        chk("midrun_rst_running", running, 1'b0);
        chk("midrun_rst_tc", tc, 1'b0);

        // Six-digit borrow chain and clamping
        load6 = 1'b1; load_val6 = 24'h100000;
        cyc(1);
        load6 = 1'b0; start6 = 1'b1;
        cyc(1);
        start6 = 1'b0;
        cyc(4);
        chk("d6_borrow", num6, 24'h099999);
        chk("d6_running", running6, 1'b1);
        load6 = 1'b1; load_val6 = 24'h0000AF;
        cyc(1);
        load6 = 1'b0;
        chk("d6_clamp", num6, 24'h000099);
        chk("d6_clamp_idle", running6, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
